// File: rtl/vscale_hasti_waitmem_if.sv
// HASTI (AHB-Lite) bus bundle between a master and the wait-state memory slave.
interface vscale_hasti_waitmem_if;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned BUS_W   = 32;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 3;
  localparam int unsigned PROT_W  = 4;
  localparam int unsigned TRANS_W = 2;

  logic               hsel;
  logic [ADDR_W-1:0]  haddr;
  logic               hwrite;
  logic [SIZE_W-1:0]  hsize;
  logic [BURST_W-1:0] hburst;
  logic               hmastlock;
  logic [PROT_W-1:0]  hprot;
  logic [TRANS_W-1:0] htrans;
  logic [BUS_W-1:0]   hwdata;
  logic [BUS_W-1:0]   hrdata;
  logic               hready;
  logic               hresp;

  modport master (
    output hsel, haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/vscale_hasti_waitmem.sv
// Word-organised HASTI slave memory with a fixed number of wait states per OKAY
// data phase and a two-cycle ERROR response for bad addresses, sizes or alignment.
module vscale_hasti_waitmem #(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                   hclk,
  input  logic                   hreset,
  vscale_hasti_waitmem_if.slave  bus
);
  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0]  HTRANS_SEQ    = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

  state_e         state_q;
  logic [3:0]     wcnt_q;
  logic           valid_q;
  logic           write_q;
  logic [AW-1:0]  widx_q;
  logic [1:0]     lane_q;
  logic [2:0]     size_q;
  logic           hready_q;
  logic           hresp_q;
  logic [31:0]    hrdata_q;

  logic [31:0]    mem [MEM_WORDS];

  logic           accept_c;
  logic           err_c;
  logic           commit_c;
  logic [AW-1:0]  aidx_c;
  logic [3:0]     be_c;
  logic [31:0]    rd_fwd_c;
  logic           unused_c;

  assign unused_c = &{1'b0, bus.hburst, bus.hmastlock, bus.hprot};

  // Address-phase decode and error classification.
  always_comb begin
    accept_c = hready_q && bus.hsel &&
               (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);
    err_c    = ({2'b00, bus.haddr[31:2]} >= 32'(MEM_WORDS)) ||
               (bus.hsize > 3'd2) ||
               (bus.hsize == 3'd1 && bus.haddr[0]) ||
               (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00);
    aidx_c   = bus.haddr[AW+1:2];
  end

  // Byte lanes of the registered transfer; write commits in its completing cycle.
  always_comb begin
    be_c = 4'b1111;
    case (size_q)
      3'd0:    be_c = 4'b0001 << lane_q;
      3'd1:    be_c = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
    commit_c = hready_q && valid_q && write_q;
  end

  // Zero-wait reads must see a write committing on the same edge.
  always_comb begin
    rd_fwd_c = mem[aidx_c];
    for (int i = 0; i < 4; i++) begin
      if (commit_c && widx_q == aidx_c && be_c[i]) begin
        rd_fwd_c[8*i +: 8] = bus.hwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (commit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[widx_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  // Transfer FSM; hready/hresp/hrdata are registered and describe the next cycle.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      widx_q   <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      hrdata_q <= '0;
    end else if (hready_q) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      valid_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      hrdata_q <= '0;
      if (accept_c) begin
        write_q <= bus.hwrite;
        widx_q  <= aidx_c;
        lane_q  <= bus.haddr[1:0];
        size_q  <= bus.hsize;
        if (err_c) begin
          state_q  <= S_ERR1;
          hready_q <= 1'b0;
          hresp_q  <= 1'b1;
        end else if (WAIT_STATES == 0) begin
          valid_q <= 1'b1;
          if (!bus.hwrite) hrdata_q <= rd_fwd_c;
        end else begin
          state_q  <= S_WAIT;
          wcnt_q   <= 4'(WAIT_STATES);
          hready_q <= 1'b0;
          valid_q  <= 1'b1;
        end
      end
    end else begin
      case (state_q)
        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            hready_q <= 1'b1;
            if (!write_q) hrdata_q <= mem[widx_q];
          end
        end
        default: begin
          state_q  <= S_IDLE;
          valid_q  <= 1'b0;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hready = hready_q;
  assign bus.hresp  = hresp_q;
  assign bus.hrdata = hrdata_q;
endmodule

// File: doc/vscale_hasti_waitmem.md
VSCALE_HASTI_WAITMEM -- requirements
Module: vscale_hasti_waitmem

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, meaning the number of 32-bit words of storage (16 KB).
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..15, meaning the number of hready-low cycles inserted in each OKAY data phase.
REQ-003 SHALL have port hclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port hreset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port hsel, input, 1 bit: slave select.
REQ-006 SHALL have port haddr, input, `HASTI_ADDR_WIDTH (32): byte address.
REQ-007 SHALL have port hwrite, input, 1 bit: 1 = write.
REQ-008 SHALL have port hsize, input, `HASTI_SIZE_WIDTH (3): transfer size, 0/1/2 = byte/half/word.
REQ-009 SHALL have ports hburst, hmastlock and hprot as inputs of widths `HASTI_BURST_WIDTH, 1 and `HASTI_PROT_WIDTH; all three are ignored.
REQ-010 SHALL have port htrans, input, `HASTI_TRANS_WIDTH (2): IDLE/BUSY/NONSEQ/SEQ.
REQ-011 SHALL have port hwdata, input, `HASTI_BUS_WIDTH (32): write data, valid in the data phase.
REQ-012 SHALL have port hrdata, output, 32 bits: read data.
REQ-013 SHALL have port hready, output, 1 bit: data phase complete.
REQ-014 SHALL have port hresp, output, 1 bit: 0 = OKAY, 1 = ERROR.

Function
REQ-015 SHALL accept an address phase when hready=1, hsel=1 and htrans is NONSEQ or SEQ; SHALL then register haddr, hwrite and hsize, and compute an error flag.
REQ-016 SHALL treat IDLE or BUSY transfers, and hsel=0, as no transfer; the next cycle is a zero-wait OKAY (hready=1, hresp=0).
REQ-017 SHALL flag an error when haddr[31:2] >= MEM_WORDS, when hsize > 2, or when the access is misaligned (half with haddr[0]=1; word with haddr[1:0] != 0).
REQ-018 SHALL implement an FSM with states IDLE, WAIT, ERR1 and ERR2.
REQ-019 IDLE: an accepted, error-free transfer with WAIT_STATES>0 SHALL go to WAIT and load wcnt=WAIT_STATES; with WAIT_STATES=0 it SHALL stay in IDLE and complete in one cycle. An accepted, flagged transfer SHALL go to ERR1.
REQ-020 WAIT: hready=0 while wcnt != 0; wcnt decrements each cycle; the cycle after wcnt reaches 0 SHALL be the completing cycle (hready=1, hresp=0), and that cycle SHALL accept a new address phase (REQ-019 applies).
REQ-021 ERR1: hready=0, hresp=1; SHALL go to ERR2 unconditionally.
REQ-022 ERR2: hready=1, hresp=1; SHALL accept a new address phase as in IDLE.
REQ-023 Address-phase inputs SHALL be ignored whenever hready=0.
REQ-024 Write: hwdata SHALL be sampled only in the completing cycle; byte lanes enabled per registered hsize and haddr[1:0] (byte: one lane; half: lanes 1:0 or 3:2; word: all). Commit occurs at that clock edge; other bytes are unchanged.
REQ-025 Errored writes SHALL NOT modify memory.
REQ-026 Read: hrdata SHALL present the full 32-bit word at the registered word address in the completing cycle, independent of hsize; hrdata=0 in every other cycle, including error cycles.
REQ-027 Read immediately following a write to the same word (including WAIT_STATES=0, back-to-back) SHALL return the newly written data.
REQ-028 Memory contents are not initialised; reads of unwritten words are X in simulation.
REQ-029 Throughput SHALL be one transfer per WAIT_STATES+1 cycles for back-to-back OKAY transfers.

Reset
REQ-030 On hreset=1, SHALL asynchronously set FSM=IDLE, wcnt=0, registered-transfer-valid=0, hready=1, hresp=0 and hrdata=0.
REQ-031 Reset asserted mid data phase SHALL abandon the transfer: no memory write, and no pending response after release.
REQ-032 Memory contents SHALL NOT be affected by reset.
REQ-033 The first address phase SHALL be accepted on the first rising edge after hreset deasserts.

Verification
REQ-034 WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then read 0x10 -> each data phase has hready=0 for 1 cycle then 1; the read returns 0xDEADBEEF with hresp=0.
REQ-035 WAIT_STATES=0, back-to-back: byte write 0xA5 to 0x13, then immediate read 0x10 -> the read completes the next cycle with hrdata[31:24]=0xA5 and the other bytes unchanged.
REQ-036 Word read at 0x4000 (word 4096, out of range) -> ERR1 cycle with hready=0/hresp=1, then ERR2 cycle with hready=1/hresp=1; hrdata=0.
REQ-037 Misaligned half write at 0x21 with hwdata=0xFFFFFFFF -> two-cycle ERROR; a later read of 0x20 shows the prior value unchanged.
REQ-038 htrans=IDLE with hsel=1 for 5 cycles -> hready=1 and hresp=0 throughout; no memory change.
REQ-039 Assert hreset during the WAIT of a write to 0x30 (WAIT_STATES=3) -> hready=1 and hresp=0 immediately; after release, a read of 0x30 returns the pre-write value.
